xfer_burst_ctrl: RTL and testbench
==================================

XFER_BURST_CTRL -- requirements
Module: xfer_burst_ctrl

Interface
REQ-001 Parameter DATA_W, 16, RAM word width in bits.
REQ-002 Parameter ADDR_W, 8, RAM address width in bits.
REQ-003 Parameter BURST_LEN, 5, words written per burst.
REQ-004 Parameter FIFO_DEPTH, 8, input buffer depth in words; power of two.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
REQ-006 The block SHALL provide the following ports:
- in_valid  in  1  input word valid
- in_ready  out  1  input buffer can accept a word
- in_data  in  DATA_W  input word
- swap_en  in  1  swap upper and lower bytes of in_data on acceptance
- start  in  1  request one burst
- base_addr  in  ADDR_W  first RAM address of the burst
- bloc_xfer  out  1  burst in progress
- ram_we  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- done  out  1  one-cycle pulse when a burst completes

Function
REQ-007 A word SHALL be accepted on any cycle where in_valid=1 and in_ready=1.
REQ-008 in_ready SHALL equal NOT full; a word offered while full SHALL NOT be accepted, and in_data need not be held stable after acceptance.
REQ-009 On acceptance with swap_en=1, the word SHALL be stored as {in_data[7:0], in_data[15:8]}; otherwise it SHALL be stored unchanged.
REQ-010 FSM states SHALL be IDLE, ARM, DONE.
REQ-011 IDLE->ARM SHALL occur on start=1; on that transition the block SHALL latch base_addr into the address counter and clear the word counter.
REQ-012 start SHALL be ignored in ARM and DONE.
REQ-013 In ARM, on each cycle with the buffer non-empty, the block SHALL pop one word.
REQ-014 A word popped in cycle N SHALL appear in cycle N+1 with ram_we=1, ram_addr equal to the current address and ram_wdata equal to the word; all three outputs SHALL be registered.
REQ-015 In ARM with the buffer empty, the block SHALL hold ram_we=0 and stall with no timeout.
REQ-016 The address counter SHALL increment by one after each write and SHALL wrap from 2^ADDR_W-1 to 0.
REQ-017 After the BURST_LEN-th pop, the FSM SHALL go to DONE; DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-018 bloc_xfer SHALL be 1 in ARM and DONE, and 0 in IDLE.
REQ-019 Push and pop in the same cycle SHALL be legal when the buffer is neither empty nor full, and occupancy SHALL be unchanged.
REQ-020 There SHALL be no empty-buffer bypass: a word pushed into an empty buffer SHALL become poppable in the next cycle.
REQ-021 Words not consumed by a burst SHALL remain buffered for the next burst.
REQ-022 ram_we SHALL be 0 in IDLE and on every cycle without a valid write.

Reset
REQ-023 While rst=1, the block SHALL set: state IDLE; buffer empty; in_ready=0; bloc_xfer, ram_we and done = 0; ram_addr and ram_wdata = 0.
REQ-024 in_ready SHALL become 1 on the first cycle after rst deasserts.
REQ-025 Reset asserted mid-burst SHALL abort the burst immediately with no further write and no done pulse, and SHALL discard buffered words.

Structure
REQ-026 Package xfer_pkg SHALL hold the DATA_W, ADDR_W, BURST_LEN and FIFO_DEPTH defaults and the FSM state enumeration.
REQ-027 The input buffer SHALL be a separate sub-module, xfer_fifo: synchronous, single clock, with push, pop, full, empty and a registered read.

Verification
REQ-028 The bench SHALL cover:
- Push 0x1234 with swap_en=1 and 0xABCD with swap_en=0, then start with base_addr=0x10 -> writes 0x3412 to 0x10 and 0xABCD to 0x11.
- Preload 5 words, start with base_addr=0xFD -> ram_addr sequence 0xFD, 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles; done one cycle after the last write.
- Start with the buffer empty, then push one word every 3 cycles -> exactly 5 writes separated by gaps of ram_we=0; done once.
- Fill 8 words with no burst running -> in_ready=0 and a 9th offered word is not accepted; start -> 5 written, 3 retained for the next burst.
- Assert rst after the 2nd write of a burst -> no further ram_we, no done, buffer empty, in_ready=1 one cycle after release.
- Pulse start during ARM -> ignored; exactly 5 writes and one done.

Source files
------------

// File: rtl/xfer_pkg.sv
// Shared defaults and FSM encoding for the burst transfer controller.
package xfer_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 8;
  localparam int BURST_LEN  = 5;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xfer_fifo.sv
// Single-clock input buffer with registered read data.
// Push is ignored when full, pop is ignored when empty.
module xfer_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rdata <= mem[rptr];
        rptr  <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/xfer_burst_ctrl.sv
// Buffers input words and writes them to RAM in fixed-length bursts
// starting at a caller-supplied base address.
module xfer_burst_ctrl
  import xfer_pkg::*;
#(
  parameter int DATA_W     = xfer_pkg::DATA_W,
  parameter int ADDR_W     = xfer_pkg::ADDR_W,
  parameter int BURST_LEN  = xfer_pkg::BURST_LEN,
  parameter int FIFO_DEPTH = xfer_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              swap_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              bloc_xfer,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              done
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] stored;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  always_comb begin
    stored = in_data;
    if (swap_en) stored[15:0] = {in_data[7:0], in_data[15:8]};
  end

  assign in_ready = ~full & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = (state == ARM) & ~empty
                  & (cnt != CNT_W'(BURST_LEN));
  assign ram_addr = addr;

  xfer_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (stored),
    .pop   (pop),
    .rdata (ram_wdata),
    .full  (full),
    .empty (empty)
  );

  // DONE is entered on the final write so done follows it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      ram_we    <= 1'b0;
      done      <= 1'b0;
      bloc_xfer <= 1'b0;
    end else begin
      ram_we <= pop;
      done   <= 1'b0;
      if (ram_we) addr <= addr + 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ARM;
            addr      <= base_addr;
            cnt       <= '0;
            bloc_xfer <= 1'b1;
          end
        end
        ARM: begin
          if (pop) cnt <= cnt + 1'b1;
          if (ram_we && cnt == CNT_W'(BURST_LEN)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bloc_xfer <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bloc_xfer <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xfer_burst_ctrl.sv
// Directed self-checking bench for xfer_burst_ctrl.
module tb_xfer_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        swap_en;
  logic        start;
  logic [7:0]  base_addr;
  logic        bloc_xfer;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nw = 0;
  int nd = 0;
  int dcyc = 0;
  logic [7:0]  wa [16];
  logic [15:0] wd [16];
  int          wc [16];

  xfer_burst_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .swap_en   (swap_en),
    .start     (start),
    .base_addr (base_addr),
    .bloc_xfer (bloc_xfer),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (ram_we === 1'b1 && nw < 16) begin
      wa[nw] = ram_addr;
      wd[nw] = ram_wdata;
      wc[nw] = cyc;
      nw = nw + 1;
    end
    if (done === 1'b1) begin
      nd = nd + 1;
      dcyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic sw);
    in_valid = 1'b1;
    in_data  = d;
    swap_en  = sw;
    tick();
    in_valid = 1'b0;
    swap_en  = 1'b0;
  endtask

  task automatic go(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic clr();
    nw = 0;
    nd = 0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    swap_en   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    run(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bloc", bloc_xfer, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready", in_ready, 1);

    // swap and plain words, burst at 0x10
    clr();
    push(16'h1234, 1'b1);
    push(16'hABCD, 1'b0);
    go(8'h10);
    chk("t1_bloc", bloc_xfer, 1);
    run(5);
    chk("t1_nw2", nw, 2);
    chk("t1_a0", wa[0], 8'h10);
    chk("t1_d0", wd[0], 16'h3412);
    chk("t1_a1", wa[1], 8'h11);
    chk("t1_d1", wd[1], 16'hABCD);
    chk("t1_nodone", nd, 0);
    push(16'h1111, 1'b0);
    push(16'h2222, 1'b0);
    push(16'h3333, 1'b0);
    run(6);
    chk("t1_nw5", nw, 5);
    chk("t1_a4", wa[4], 8'h14);
    chk("t1_d4", wd[4], 16'h3333);
    chk("t1_done", nd, 1);
    chk("t1_idle", bloc_xfer, 0);

    // address wrap from 0xFD
    clr();
    for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i), 1'b0);
    go(8'hFD);
    run(10);
    chk("t2_nw", nw, 5);
    chk("t2_a0", wa[0], 8'hFD);
    chk("t2_a1", wa[1], 8'hFE);
    chk("t2_a2", wa[2], 8'hFF);
    chk("t2_a3", wa[3], 8'h00);
    chk("t2_a4", wa[4], 8'h01);
    chk("t2_d2", wd[2], 16'h5002);
    for (int i = 1; i < 5; i++) chk("t2_consec", wc[i] - wc[i-1], 1);
    chk("t2_done", nd, 1);
    chk("t2_dcyc", dcyc - wc[4], 1);

    // start empty, trickle one word every 3 cycles
    clr();
    go(8'h40);
    run(4);
    chk("t3_stall", nw, 0);
    chk("t3_stall_bloc", bloc_xfer, 1);
    for (int i = 0; i < 5; i++) begin
      push(16'h7000 + 16'(i), 1'b0);
      run(2);
    end
    run(5);
    chk("t3_nw", nw, 5);
    for (int i = 1; i < 5; i++) chk("t3_gap", wc[i] - wc[i-1], 3);
    chk("t3_a4", wa[4], 8'h44);
    chk("t3_d4", wd[4], 16'h7004);
    chk("t3_done", nd, 1);

    // fill to full, 9th word rejected, 3 retained
    clr();
    for (int i = 0; i < 8; i++) push(16'h8000 + 16'(i), 1'b0);
    chk("t4_full", in_ready, 0);
    push(16'hDEAD, 1'b0);
    go(8'h20);
    run(10);
    chk("t4_nw", nw, 5);
    chk("t4_d0", wd[0], 16'h8000);
    chk("t4_d4", wd[4], 16'h8004);
    chk("t4_done", nd, 1);
    clr();
    go(8'h30);
    run(6);
    chk("t4_kept", nw, 3);
    chk("t4_k2", wd[2], 16'h8007);
    chk("t4_ka2", wa[2], 8'h32);
    push(16'h9000, 1'b0);
    push(16'h9001, 1'b0);
    run(6);
    chk("t4_nw2", nw, 5);
    chk("t4_d3", wd[3], 16'h9000);
    chk("t4_done2", nd, 1);

    // reset after the second write
    clr();
    for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i), 1'b0);
    go(8'h50);
    run(2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_we", ram_we, 0);
    chk("t5_bloc", bloc_xfer, 0);
    chk("t5_nw", nw, 2);
    chk("t5_a1", wa[1], 8'h51);
    run(2);
    chk("t5_rdy_rst", in_ready, 0);
    rst = 1'b0;
    tick();
    chk("t5_rdy", in_ready, 1);
    run(8);
    chk("t5_nowr", nw, 2);
    chk("t5_nodone", nd, 0);
    go(8'h60);
    run(5);
    chk("t5_empty", nw, 2);
    chk("t5_stall", bloc_xfer, 1);

    // start pulsed during ARM is ignored
    clr();
    push(16'hB000, 1'b0);
    push(16'hB001, 1'b0);
    go(8'h90);
    for (int i = 2; i < 5; i++) push(16'hB000 + 16'(i), 1'b0);
    run(10);
    chk("t6_nw", nw, 5);
    chk("t6_a0", wa[0], 8'h60);
    chk("t6_a4", wa[4], 8'h64);
    chk("t6_d4", wd[4], 16'hB004);
    chk("t6_done", nd, 1);
    chk("t6_idle", bloc_xfer, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
